// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - instruction type codes, writeback FSM states and write-qualify helper
package writeback_pkg;

  localparam logic [4:0] RTYPE = 5'b00001;
  localparam logic [4:0] ITYPE = 5'b00010;
  localparam logic [4:0] STYPE = 5'b00100;
  localparam logic [4:0] UTYPE = 5'b01000;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_PULSE = 2'd1,
    WB_GAP   = 2'd2
  } wb_state_e;

  // Stores, writes to x0 and unrecognised types travel the FIFO as nulls.
  function automatic logic wb_is_write(input logic [4:0] itype, input logic [4:0] rd);
    return ((itype == RTYPE) || (itype == ITYPE) || (itype == UTYPE)) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/writeback_fifo.sv
// rtl/writeback_fifo.sv - power-of-two result FIFO with registered occupancy count
module writeback_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 38,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - buffers execute results and drives the register-file write strobe and busy scoreboard
module writeback
  import writeback_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            res_valid_i,
  output logic            res_ready_o,
  input  logic [XLEN-1:0] res_data_i,
  input  logic [XLEN-1:0] pass_i,
  input  logic [4:0]      rd_i,
  input  logic [4:0]      itype_i,
  input  logic            issue_i,
  input  logic [4:0]      issue_rd_i,
  output logic [XLEN-1:0] wd_o,
  output logic [4:0]      wd_addr_o,
  output logic            wd_q_o,
  output logic [31:0]     busy_o
);

  localparam int EW = XLEN + 6;
  localparam int CW = $clog2(DEPTH + 1);

  wb_state_e       state_q;
  logic [XLEN-1:0] wd_q;
  logic [4:0]      wd_addr_q;
  logic            strobe_q;
  logic [31:0]     busy_q;
  logic [31:0]     busy_d;

  logic [XLEN-1:0] sel_data;
  logic [EW-1:0]   entry_in;
  logic [EW-1:0]   head;
  logic            head_null;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count_unused;
  logic            pass_unused;
  logic            push;
  logic            pop;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  assign pass_unused = ^pass_i[XLEN-1:20];

  assign sel_data  = (itype_i == UTYPE) ? XLEN'({pass_i[19:0], 12'b0}) : res_data_i;
  assign entry_in  = {~wb_is_write(itype_i, rd_i), rd_i, sel_data};
  assign head_null = head[EW-1];
  assign head_rd   = head[XLEN +: 5];
  assign head_data = head[XLEN-1:0];

  assign res_ready_o = !fifo_full;
  assign push        = res_valid_i && res_ready_o;
  assign pop         = (state_q == WB_IDLE) && !fifo_empty;

  writeback_fifo #(
    .DEPTH (DEPTH),
    .W     (EW),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (entry_in),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  // Strobe is one cycle high, then address/data hold through GAP so decode can edge-capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WB_IDLE;
      wd_q      <= '0;
      wd_addr_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          strobe_q <= 1'b0;
          if (!fifo_empty && !head_null) begin
            wd_q      <= head_data;
            wd_addr_q <= head_rd;
            strobe_q  <= 1'b1;
            state_q   <= WB_PULSE;
          end
        end
        WB_PULSE: begin
          strobe_q <= 1'b0;
          state_q  <= WB_GAP;
        end
        default: begin
          strobe_q <= 1'b0;
          state_q  <= WB_IDLE;
        end
      endcase
    end
  end

  // A new issue to the register being retired wins: a younger write is now in flight.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_i && (issue_rd_i != 5'd0)) set_mask = 32'd1 << issue_rd_i;
    if (state_q == WB_PULSE)            clr_mask = 32'd1 << wd_addr_q;
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign wd_o      = wd_q;
  assign wd_addr_o = wd_addr_q;
  assign wd_q_o    = strobe_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - scoreboard bench for the writeback result buffer and write strobe
module tb_writeback;
  import writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        res_valid_i = 1'b0;
  logic        res_ready_o;
  logic [31:0] res_data_i = '0;
  logic [31:0] pass_i = '0;
  logic [4:0]  rd_i = '0;
  logic [4:0]  itype_i = '0;
  logic        issue_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic [31:0] wd_o;
  logic [4:0]  wd_addr_o;
  logic        wd_q_o;
  logic [31:0] busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_strobes = 0;
  int rise_q[$];
  logic [36:0] exp_q[$];
  logic [31:0] exp_busy = '0;
  logic        prev = 1'b0;
  logic [31:0] last_data = '0;

  writeback #(.DEPTH(2), .XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .res_valid_i (res_valid_i),
    .res_ready_o (res_ready_o),
    .res_data_i  (res_data_i),
    .pass_i      (pass_i),
    .rd_i        (rd_i),
    .itype_i     (itype_i),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .wd_o        (wd_o),
    .wd_addr_o   (wd_addr_o),
    .wd_q_o      (wd_q_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [4:0] rd, input logic [4:0] it, input logic [31:0] d,
                      input logic [31:0] p);
    int n = 0;
    logic [31:0] e;
    @(negedge clk);
    res_valid_i = 1'b1;
    rd_i = rd;
    itype_i = it;
    res_data_i = d;
    pass_i = p;
    while (!res_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
    else if ((it == RTYPE || it == ITYPE || it == UTYPE) && rd != 5'd0) begin
      e = (it == UTYPE) ? {p[19:0], 12'h000} : d;
      exp_q.push_back({rd, e});
    end
    @(posedge clk);
    #1 res_valid_i = 1'b0;
  endtask

  task automatic wait_strobe();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wd_q_o && n < 20);
    if (!wd_q_o) check("strobe_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [4:0] rd);
    @(negedge clk);
    issue_i = 1'b1;
    issue_rd_i = rd;
    if (rd != 5'd0) exp_busy[rd] = 1'b1;
    @(negedge clk);
    issue_i = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (reset) begin
      prev = 1'b0;
    end else begin
      if (wd_q_o && !prev) begin
        rise_q.push_back(cyc);
        n_strobes++;
        if (exp_q.size() == 0) check("spurious_strobe", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("wd_addr", {27'd0, wd_addr_o}, {27'd0, e[36:32]});
          check("wd_data", wd_o, e[31:0]);
        end
        last_data = wd_o;
      end else if (prev) begin
        check("strobe_one_cycle", {31'd0, wd_q_o}, 32'd0);
        check("hold_data", wd_o, last_data);
      end
      prev = wd_q_o;
    end
  end

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    check("rst_strobe", {31'd0, wd_q_o}, 32'd0);
    check("rst_wd", wd_o, 32'd0);
    check("rst_addr", {27'd0, wd_addr_o}, 32'd0);
    check("rst_busy", busy_o, 32'd0);
    check("rst_ready", {31'd0, res_ready_o}, 32'd1);
    reset = 1'b0;

    // single write latency
    send(5'd5, RTYPE, 32'h0000_1234, 32'h0);
    @(negedge clk);
    check("lat_not_yet", {31'd0, wd_q_o}, 32'd0);
    @(negedge clk);
    check("lat_rise", {31'd0, wd_q_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("busy_clear_unset", busy_o, exp_busy);

    send(5'd3, UTYPE, 32'hdead_beef, 32'h000A_BCDE);
    send(5'd6, ITYPE, 32'h0000_55aa, 32'hffff_ffff);
    repeat (8) @(negedge clk);

    // nulls consume entries silently
    n0 = n_strobes;
    send(5'd4, STYPE, 32'h1111_1111, 32'h0);
    send(5'd0, RTYPE, 32'h2222_2222, 32'h0);
    send(5'd8, 5'b10000, 32'h3333_3333, 32'h0);
    repeat (6) @(negedge clk);
    check("null_no_strobe", n_strobes, n0);
    check("null_busy", busy_o, exp_busy);
    check("null_ready", {31'd0, res_ready_o}, 32'd1);

    // back-to-back fill and strobe spacing
    rise_q.delete();
    send(5'd10, RTYPE, 32'hA0A0_0010, 32'h0);
    send(5'd11, RTYPE, 32'hA0A0_0011, 32'h0);
    send(5'd12, ITYPE, 32'hA0A0_0012, 32'h0);
    @(negedge clk);
    check("ready_full", {31'd0, res_ready_o}, 32'd0);
    repeat (12) @(negedge clk);
    check("b2b_count", rise_q.size(), 32'd3);
    if (rise_q.size() == 3) begin
      check("b2b_gap0", rise_q[1] - rise_q[0], 32'd3);
      check("b2b_gap1", rise_q[2] - rise_q[1], 32'd3);
    end

    // scoreboard
    issue(5'd7);
    check("busy_set7", busy_o, exp_busy);
    issue(5'd0);
    check("busy_x0_ignored", busy_o, exp_busy);
    send(5'd7, RTYPE, 32'h0000_0077, 32'h0);
    wait_strobe();
    check("busy_in_pulse", {31'd0, busy_o[7]}, 32'd1);
    @(negedge clk);
    exp_busy[7] = 1'b0;
    check("busy_cleared", busy_o, exp_busy);
    issue(5'd7);
    send(5'd7, RTYPE, 32'h0000_0078, 32'h0);
    wait_strobe();
    issue_i = 1'b1;
    issue_rd_i = 5'd7;
    @(negedge clk);
    issue_i = 1'b0;
    check("busy_set_wins", busy_o, exp_busy);
    send(5'd7, ITYPE, 32'h0000_0079, 32'h0);
    wait_strobe();
    @(negedge clk);
    exp_busy[7] = 1'b0;
    check("busy_cleared2", busy_o, exp_busy);
    repeat (3) @(negedge clk);

    // reset while a write is mid-pulse with two entries behind it
    issue(5'd20);
    send(5'd20, RTYPE, 32'hC0C0_0020, 32'h0);
    send(5'd21, RTYPE, 32'hC0C0_0021, 32'h0);
    send(5'd22, RTYPE, 32'hC0C0_0022, 32'h0);
    wait_strobe();
    #1 reset = 1'b1;
    #1;
    check("rst_mid_strobe", {31'd0, wd_q_o}, 32'd0);
    check("rst_mid_busy", busy_o, 32'd0);
    check("rst_mid_ready", {31'd0, res_ready_o}, 32'd1);
    exp_q.delete();
    exp_busy = '0;
    n0 = n_strobes;
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_no_strobes", n_strobes, n0);
    check("rst_after_ready", {31'd0, res_ready_o}, 32'd1);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
